// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared Size encodings, FSM states and byte-count helper for the data memory
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bytes touched by an access; the reserved encoding reports zero and is rejected separately.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_WORD: return 3'd4;
            SZ_HALF: return 3'd2;
            SZ_BYTE: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// rtl/dmem_byte_array.sv - DEPTH x 8 storage with one byte port and one big-endian 4-byte port
module dmem_byte_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          byte_we,
    input  logic [AW-1:0] byte_addr,
    input  logic [7:0]    byte_wdata,
    output logic [7:0]    byte_rdata,
    input  logic [3:0]    wide_be,
    input  logic [AW-1:0] wide_addr,
    input  logic [31:0]   wide_wdata,
    output logic [31:0]   wide_rdata
);

    logic [7:0] mem [DEPTH];

    // Writes: byte port, then the wide port; lane 3 (bits 31:24) lands at wide_addr, lanes wrap modulo DEPTH.
    always_ff @(posedge Clk) begin
        if (byte_we) begin
            mem[byte_addr] <= byte_wdata;
        end
        for (int k = 0; k < 4; k++) begin
            if (wide_be[3-k]) begin
                mem[wide_addr + AW'(k)] <= wide_wdata[31-8*k -: 8];
            end
        end
    end

    // Reads are combinational so the controller can register the result at the accepting edge.
    always_comb begin
        byte_rdata = mem[byte_addr];
        wide_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            wide_rdata[31-8*k -: 8] = mem[wide_addr + AW'(k)];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - big-endian load/store data memory controller; define MISALIGN_EN for byte-serial misaligned accesses
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic              RespValid,
    output logic [DATA_W-1:0] DataOut,
    output logic              Error
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    state_t          state, state_nx;
    logic            accept, req_ok, req_err, misaligned, use_byte;
    logic [2:0]      nbytes;
    logic [ADDR_W:0] end_addr;
    logic [31:0]     lj_data, rd_now, data_q;
    logic            err_q;

    logic            byte_we;
    logic [AW-1:0]   byte_addr;
    logic [7:0]      byte_wdata, byte_rdata;
    logic [3:0]      wide_be;
    logic [31:0]     wide_rdata;

`ifdef MISALIGN_EN
    logic [1:0]      cnt, last_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wsh_q;
    logic            rw_q;
`endif

    dmem_byte_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .Clk        (Clk),
        .byte_we    (byte_we),
        .byte_addr  (byte_addr),
        .byte_wdata (byte_wdata),
        .byte_rdata (byte_rdata),
        .wide_be    (wide_be),
        .wide_addr  (Address[AW-1:0]),
        .wide_wdata (lj_data),
        .wide_rdata (wide_rdata)
    );

    // Request decode: range check in ADDR_W+1 bits so addresses near the top never wrap back in range.
    always_comb begin
        nbytes     = size_bytes(Size);
        end_addr   = {1'b0, Address} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
        misaligned = ((Size == SZ_WORD) && (Address[1:0] != 2'b00)) ||
                     ((Size == SZ_HALF) && Address[0]);
        req_err    = (Size == SZ_RSVD) || (end_addr > LAST_ADDR);
`ifndef MISALIGN_EN
        req_err    = req_err || misaligned;
`endif
        accept     = ReqValid && (state == ST_IDLE);
        req_ok     = accept && !req_err;
        use_byte   = (Size == SZ_BYTE);
`ifdef MISALIGN_EN
        use_byte   = use_byte || misaligned;
`endif
    end

    // Left-justify store data so byte 0 of every access sits in bits 31:24.
    always_comb begin
        case (Size)
            SZ_HALF: lj_data = {DataIn[15:0], 16'h0000};
            SZ_BYTE: lj_data = {DataIn[7:0], 24'h000000};
            default: lj_data = DataIn;
        endcase
    end

    // Aligned word/half go through the wide port; bytes and the first misaligned beat use the byte port.
    always_comb begin
        wide_be = 4'b0000;
        if (req_ok && RW && !use_byte) begin
            wide_be = (Size == SZ_HALF) ? 4'b1100 : 4'b1111;
        end
        if (use_byte) begin
            rd_now = {24'h000000, byte_rdata};
        end else if (Size == SZ_HALF) begin
            rd_now = {16'h0000, wide_rdata[31:16]};
        end else begin
            rd_now = wide_rdata;
        end
    end

    // Byte port steering: live request in IDLE, captured address plus beat index while serialising.
    always_comb begin
        byte_addr  = Address[AW-1:0];
        byte_wdata = lj_data[31:24];
        byte_we    = req_ok && RW && use_byte;
`ifdef MISALIGN_EN
        if (state == ST_BEAT) begin
            byte_addr  = addr_q + AW'(cnt);
            byte_wdata = wsh_q[31:24];
            byte_we    = rw_q;
        end
`endif
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: begin
                state_nx = ST_IDLE;
                if (accept) begin
                    state_nx = ST_RESP;
`ifdef MISALIGN_EN
                    if (req_ok && misaligned) begin
                        state_nx = ST_BEAT;
                    end
`endif
                end
            end
`ifdef MISALIGN_EN
            ST_BEAT: state_nx = (cnt == last_q) ? ST_RESP : ST_BEAT;
`endif
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Response datapath; beat 0 of a misaligned access happens at the accepting edge itself.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            data_q <= 32'h0;
            err_q  <= 1'b0;
`ifdef MISALIGN_EN
            cnt    <= 2'd0;
            last_q <= 2'd0;
            addr_q <= '0;
            wsh_q  <= 32'h0;
            rw_q   <= 1'b0;
`endif
        end else if (accept) begin
            err_q  <= req_err;
            data_q <= (req_ok && !RW) ? rd_now : 32'h0;
`ifdef MISALIGN_EN
            cnt    <= 2'd1;
            last_q <= 2'(nbytes - 3'd1);
            addr_q <= Address[AW-1:0];
            wsh_q  <= {lj_data[23:0], 8'h00};
            rw_q   <= RW;
        end else if (state == ST_BEAT) begin
            cnt   <= cnt + 2'd1;
            wsh_q <= {wsh_q[23:0], 8'h00};
            if (!rw_q) begin
                data_q <= {data_q[23:0], byte_rdata};
            end
`endif
        end
    end

    // Outputs: ready only in IDLE, response fields visible only during the RESP pulse.
    always_comb begin
        ReqReady  = (state == ST_IDLE);
        RespValid = (state == ST_RESP);
        DataOut   = RespValid ? data_q : '0;
        Error     = RespValid && err_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl (both MISALIGN_EN builds)
module tb_data_mem_ctrl;

    localparam logic [1:0] SW = 2'b00;
    localparam logic [1:0] SB = 2'b01;
    localparam logic [1:0] SH = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    logic        Clk = 1'b0;
    logic        Reset, ReqValid, ReqReady, RW, RespValid, Error;
    logic [1:0]  Size;
    logic [31:0] Address, DataIn, DataOut;

    int n_checks = 0;
    int n_fails  = 0;
    int acc, rsp, cyc, extra;
    logic rdy;

    logic        hh_rw   [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  hh_sz   [10] = '{SW, SW, SH, SW, SB, SH, SW, SB, SB, SW};
    logic [31:0] hh_addr [10] = '{32'd32, 32'd32, 32'd34, 32'd32, 32'd33, 32'd32, 32'd36, 32'd39, 32'd36, 32'd36};
    logic [31:0] hh_data [10] = '{32'h11223344, 32'h0, 32'h0000AABB, 32'h0, 32'hFFFFFFCC,
                                  32'h0, 32'h0F0E0D0C, 32'h0, 32'h12345699, 32'h0};
    logic [31:0] hh_exp  [10] = '{32'h0, 32'h11223344, 32'h0, 32'h1122AABB, 32'h0,
                                  32'h000011CC, 32'h0, 32'h0000000C, 32'h0, 32'h990E0D0C};

    always #5 Clk = ~Clk;

    data_mem_ctrl #(.DEPTH(256), .ADDR_W(32), .DATA_W(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .RW        (RW),
        .Size      (Size),
        .Address   (Address),
        .DataIn    (DataIn),
        .RespValid (RespValid),
        .DataOut   (DataOut),
        .Error     (Error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, {31'h0, ReqReady}, 32'h1);
        check({tag, "_resp"},  {31'h0, RespValid}, 32'h0);
        check({tag, "_data"},  DataOut, 32'h0);
        check({tag, "_err"},   {31'h0, Error}, 32'h0);
    endtask

    task automatic issue(input logic rw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] dout, output logic err);
        int w;
        @(negedge Clk);
        RW = rw; Size = sz; Address = a; DataIn = d; ReqValid = 1'b1;
        w = 0;
        while (!ReqReady && w < 20) begin
            @(negedge Clk);
            w++;
        end
        @(posedge Clk);
        #1;
        ReqValid = 1'b0; RW = ~rw; Address = ~a; DataIn = ~d;
        lat = 0; dout = 32'h0; err = 1'b0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!RespValid && lat < 20);
        if (!RespValid) begin
            lat = -1;
        end else begin
            dout = DataOut;
            err  = Error;
        end
    endtask

    task automatic op(input string tag, input logic rw, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat, input logic [31:0] exp_dout, input logic exp_err);
        int lat;
        logic [31:0] dout;
        logic err;
        issue(rw, sz, a, d, lat, dout, err);
        check({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "_data"}, dout, exp_dout);
        check({tag, "_err"},  {31'h0, err}, {31'h0, exp_err});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; RW = 1'b0; Size = SW; Address = 32'h0; DataIn = 32'h0;
        #12;
        check_reset("rst");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_reset("post_rst");

        op("sw8",  1'b1, SW, 32'd8, 32'hDEADBEEF, 1, 32'h0, 1'b0);
        op("lw8",  1'b0, SW, 32'd8, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        op("lb8",  1'b0, SB, 32'd8, 32'h0, 1, 32'h000000DE, 1'b0);
        op("sh6",  1'b1, SH, 32'd6, 32'h00001234, 1, 32'h0, 1'b0);
        op("lb6",  1'b0, SB, 32'd6, 32'h0, 1, 32'h00000012, 1'b0);
        op("lb7",  1'b0, SB, 32'd7, 32'h0, 1, 32'h00000034, 1'b0);
        op("lh6",  1'b0, SH, 32'd6, 32'h0, 1, 32'h00001234, 1'b0);

        op("lw254",   1'b0, SW, 32'd254, 32'h0, 1, 32'h0, 1'b1);
        op("rsvd_st", 1'b1, SR, 32'd8, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
        op("lw8_chk", 1'b0, SW, 32'd8, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        op("sh254",   1'b1, SH, 32'd254, 32'h0000C0DE, 1, 32'h0, 1'b0);
        op("sw254",   1'b1, SW, 32'd254, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
        op("lh254",   1'b0, SH, 32'd254, 32'h0, 1, 32'h0000C0DE, 1'b0);
        op("lh255",   1'b0, SH, 32'd255, 32'h0, 1, 32'h0, 1'b1);
        op("lb255",   1'b0, SB, 32'd255, 32'h0, 1, 32'h000000DE, 1'b0);
        op("lw_top",  1'b0, SW, 32'hFFFFFFFE, 32'h0, 1, 32'h0, 1'b1);

        op("sb5", 1'b1, SB, 32'd5, 32'h00000055, 1, 32'h0, 1'b0);
`ifdef MISALIGN_EN
        op("sw5_mis", 1'b1, SW, 32'd5, 32'hA1B2C3D4, 4, 32'h0, 1'b0);
        op("m_lb5",   1'b0, SB, 32'd5, 32'h0, 1, 32'h000000A1, 1'b0);
        op("m_lb6",   1'b0, SB, 32'd6, 32'h0, 1, 32'h000000B2, 1'b0);
        op("m_lb7",   1'b0, SB, 32'd7, 32'h0, 1, 32'h000000C3, 1'b0);
        op("m_lb8",   1'b0, SB, 32'd8, 32'h0, 1, 32'h000000D4, 1'b0);
        op("lw5_mis", 1'b0, SW, 32'd5, 32'h0, 4, 32'hA1B2C3D4, 1'b0);
        op("lh7_mis", 1'b0, SH, 32'd7, 32'h0, 2, 32'h0000C3D4, 1'b0);
`else
        op("sw5_mis", 1'b1, SW, 32'd5, 32'hA1B2C3D4, 1, 32'h0, 1'b1);
        op("m_lb5",   1'b0, SB, 32'd5, 32'h0, 1, 32'h00000055, 1'b0);
        op("m_lb6",   1'b0, SB, 32'd6, 32'h0, 1, 32'h00000012, 1'b0);
        op("m_lb7",   1'b0, SB, 32'd7, 32'h0, 1, 32'h00000034, 1'b0);
        op("m_lb8",   1'b0, SB, 32'd8, 32'h0, 1, 32'h000000DE, 1'b0);
        op("lh7_mis", 1'b0, SH, 32'd7, 32'h0, 1, 32'h0, 1'b1);
`endif

        // ReqValid held high across ten alternating stores and loads.
        acc = 0; rsp = 0; cyc = 0;
        @(negedge Clk);
        RW = hh_rw[0]; Size = hh_sz[0]; Address = hh_addr[0]; DataIn = hh_data[0]; ReqValid = 1'b1;
        while (rsp < 10 && cyc < 200) begin
            rdy = ReqReady;
            if (RespValid) begin
                check($sformatf("hh%0d_data", rsp), DataOut, hh_exp[rsp]);
                check($sformatf("hh%0d_err", rsp), {31'h0, Error}, 32'h0);
                check($sformatf("hh%0d_rdy", rsp), {31'h0, ReqReady}, 32'h0);
                rsp++;
            end
            @(posedge Clk);
            #1;
            if (rdy && acc < 10) begin
                acc++;
                if (acc < 10) begin
                    RW = hh_rw[acc]; Size = hh_sz[acc]; Address = hh_addr[acc]; DataIn = hh_data[acc];
                end else begin
                    ReqValid = 1'b0;
                end
            end
            @(negedge Clk);
            cyc++;
        end
        ReqValid = 1'b0;
        check("hh_accepted", 32'(acc), 32'd10);
        check("hh_responses", 32'(rsp), 32'd10);
        extra = 0;
        repeat (6) begin
            @(negedge Clk);
            if (RespValid) extra++;
        end
        check("hh_extra_resp", 32'(extra), 32'd0);

        // Reset while the response of an aligned store is pending.
        @(negedge Clk);
        RW = 1'b1; Size = SW; Address = 32'd12; DataIn = 32'h5555AAAA; ReqValid = 1'b1;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        check("rstA_resp_before", {31'h0, RespValid}, 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset("rstA");
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rstA_noresp", {31'h0, RespValid}, 32'h0);
        op("lw12", 1'b0, SW, 32'd12, 32'h0, 1, 32'h5555AAAA, 1'b0);

`ifdef MISALIGN_EN
        // Reset during beat 2 of a misaligned store leaves a partial write.
        op("pre5", 1'b1, SB, 32'd5, 32'h11, 1, 32'h0, 1'b0);
        op("pre6", 1'b1, SB, 32'd6, 32'h22, 1, 32'h0, 1'b0);
        op("pre7", 1'b1, SB, 32'd7, 32'h33, 1, 32'h0, 1'b0);
        op("pre8", 1'b1, SB, 32'd8, 32'h44, 1, 32'h0, 1'b0);
        @(negedge Clk);
        RW = 1'b1; Size = SW; Address = 32'd5; DataIn = 32'hA1B2C3D4; ReqValid = 1'b1;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        check("rstB_busy", {31'h0, ReqReady}, 32'h0);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check_reset("rstB");
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rstB_noresp", {31'h0, RespValid}, 32'h0);
        op("p_lb5", 1'b0, SB, 32'd5, 32'h0, 1, 32'h000000A1, 1'b0);
        op("p_lb6", 1'b0, SB, 32'd6, 32'h0, 1, 32'h000000B2, 1'b0);
        op("p_lb7", 1'b0, SB, 32'd7, 32'h0, 1, 32'h00000033, 1'b0);
        op("p_lb8", 1'b0, SB, 32'd8, 32'h0, 1, 32'h00000044, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
